// File: rtl/frost32_mem_access_ctrl_pkg.sv
// Shared types for the Frost32 data-memory access controller.
//   DataInoutAccessType / DataInoutAccessSize : CPU mem-access request encodings
//   MemCtrlState                              : controller FSM states
//   PortOut_Frost32MemCtrlBus                 : registered word-bus request fields
package frost32_mem_access_ctrl_pkg;

  typedef enum logic {
    DiatRead  = 1'b0,
    DiatWrite = 1'b1
  } DataInoutAccessType;

  typedef enum logic [1:0] {
    Dias32  = 2'd0,
    Dias16  = 2'd1,
    Dias8   = 2'd2,
    DiasBad = 2'd3
  } DataInoutAccessSize;

  typedef enum logic [1:0] {
    StMcIdle = 2'd0,
    StMcBus  = 2'd1,
    StMcErr  = 2'd2
  } MemCtrlState;

  // Timeout counter is 8 bits wide.
  localparam int MSB_POS__MEM_CTRL_TIMEOUT_CNT = 7;

  // Widest word address a 32-bit byte address can carry; the top module
  // uses only the low MEM_ADDR_WIDTH bits of this field.
  localparam int MEM_CTRL_ADDR_W = 30;

  typedef struct packed {
    logic                       mem_req;
    logic                       mem_we;
    logic [MEM_CTRL_ADDR_W-1:0] mem_addr;
    logic [3:0]                 mem_byte_en;
    logic [31:0]                mem_wdata;
  } PortOut_Frost32MemCtrlBus;

endpackage

// File: rtl/frost32_byte_lane_unit.sv
// Combinational byte-lane steering for Dias32/16/8 accesses.
//   size, addr_lo   : access size and byte offset within the word
//   wdata           : right-justified store data
//   rdata           : raw word from the memory bus
//   be              : lane enables (bit i = bits [8i+7:8i])
//   wdata_rep       : store data replicated across all lanes
//   rdata_ext       : selected lane(s) shifted down and zero-extended
//   misalign        : size/offset combination is not naturally aligned
module frost32_byte_lane_unit
  import frost32_mem_access_ctrl_pkg::*;
(
  input  DataInoutAccessSize size,
  input  logic [1:0]         addr_lo,
  input  logic [31:0]        wdata,
  input  logic [31:0]        rdata,
  output logic [3:0]         be,
  output logic [31:0]        wdata_rep,
  output logic [31:0]        rdata_ext,
  output logic               misalign
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = 32'd0;
    misalign  = 1'b0;
    case (size)
      Dias32: begin
        be        = 4'b1111;
        rdata_ext = shifted;
        misalign  = (addr_lo != 2'b00);
      end
      Dias16: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'h0000, shifted[15:0]};
        misalign  = addr_lo[0];
      end
      Dias8: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'h000000, shifted[7:0]};
      end
      default: begin
        // DiasBad is rejected by the controller before any lane is used.
        be        = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/frost32_mem_access_ctrl.sv
// Frost32 data-memory controller: turns one CPU mem-access request into one
// transaction on a word-wide req/ack bus, returns load data and wait_for_mem.
//   clk, rst                 : clock, async active-high reset
//   cpu_req/addr/wdata/...   : request from the CPU mem-access port
//   cpu_rdata, cpu_wait      : load data (zero-extended) and stall to the CPU
//   err_sticky               : any faulted access since reset
//   mem_req/we/addr/byte_en/wdata, mem_rdata, mem_ack : memory bus
module frost32_mem_access_ctrl
  import frost32_mem_access_ctrl_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  input  logic                      cpu_acc_type,
  input  logic [1:0]                cpu_acc_size,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_wait,
  output logic                      err_sticky,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]                mem_byte_en,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  input  logic                      mem_ack
);

  localparam int TW = MSB_POS__MEM_CTRL_TIMEOUT_CNT + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  MemCtrlState              state;
  PortOut_Frost32MemCtrlBus bus;
  DataInoutAccessSize       size_q;
  logic [1:0]               addr_lo_q;
  logic [TW-1:0]            tmo_cnt;

  DataInoutAccessSize req_size;
  DataInoutAccessSize lane_size;
  logic [1:0]         lane_addr;
  logic [3:0]         lane_be;
  logic [31:0]        lane_wdata;
  logic [31:0]        lane_rdata;
  logic               lane_misalign;
  logic               out_of_range;
  logic               illegal;
  logic               timed_out;

  assign req_size = DataInoutAccessSize'(cpu_acc_size);

  // One lane unit serves both directions: while idle it sees the incoming
  // request (to build be/wdata), afterwards the latched request (to extract
  // read data at mem_ack), so a cpu_req poked mid-transaction cannot disturb it.
  assign lane_size = (state == StMcIdle) ? req_size : size_q;
  assign lane_addr = (state == StMcIdle) ? cpu_addr[1:0] : addr_lo_q;

  frost32_byte_lane_unit u_lane (
    .size      (lane_size),
    .addr_lo   (lane_addr),
    .wdata     (cpu_wdata),
    .rdata     (mem_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata),
    .misalign  (lane_misalign)
  );

  assign out_of_range = (cpu_addr >> (MEM_ADDR_WIDTH + 2)) != 32'd0;
  assign illegal      = lane_misalign || (req_size == DiasBad) || out_of_range;
  assign timed_out    = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StMcIdle;
      bus        <= '0;
      size_q     <= Dias32;
      addr_lo_q  <= 2'b00;
      tmo_cnt    <= '0;
      cpu_rdata  <= 32'd0;
      cpu_wait   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        StMcIdle: begin
          if (cpu_req) begin
            size_q    <= req_size;
            addr_lo_q <= cpu_addr[1:0];
            cpu_wait  <= 1'b1;
            tmo_cnt   <= '0;
            if (illegal) begin
              // Bus fields are left alone: a faulted write never reaches memory.
              state <= StMcErr;
            end else begin
              state           <= StMcBus;
              bus.mem_req     <= 1'b1;
              bus.mem_we      <= (cpu_acc_type == DiatWrite);
              bus.mem_addr    <= MEM_CTRL_ADDR_W'(cpu_addr[MEM_ADDR_WIDTH+1:2]);
              bus.mem_byte_en <= lane_be;
              bus.mem_wdata   <= lane_wdata;
            end
          end
        end
        StMcBus: begin
          // mem_ack takes priority over a timeout in the same cycle.
          if (mem_ack) begin
            if (!bus.mem_we) cpu_rdata <= lane_rdata;
            bus.mem_req <= 1'b0;
            cpu_wait    <= 1'b0;
            state       <= StMcIdle;
          end else if (timed_out) begin
            bus.mem_req <= 1'b0;
            cpu_wait    <= 1'b0;
            cpu_rdata   <= 32'd0;
            err_sticky  <= 1'b1;
            state       <= StMcIdle;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        StMcErr: begin
          cpu_rdata  <= 32'd0;
          err_sticky <= 1'b1;
          cpu_wait   <= 1'b0;
          state      <= StMcIdle;
        end
        default: state <= StMcIdle;
      endcase
    end
  end

  assign mem_req     = bus.mem_req;
  assign mem_we      = bus.mem_we;
  assign mem_addr    = bus.mem_addr[MEM_ADDR_WIDTH-1:0];
  assign mem_byte_en = bus.mem_byte_en;
  assign mem_wdata   = bus.mem_wdata;

  // Word-address bits above MEM_ADDR_WIDTH are always zero (range check).
  logic unused_addr_hi;
  assign unused_addr_hi = ^(bus.mem_addr >> MEM_ADDR_WIDTH);

endmodule

// File: tb/tb_frost32_mem_access_ctrl.sv
module tb_frost32_mem_access_ctrl;
  import frost32_mem_access_ctrl_pkg::*;

  localparam int MAW = 16;
  localparam int TMO = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cpu_req = 1'b0;
  logic [31:0]     cpu_addr = '0;
  logic [31:0]     cpu_wdata = '0;
  logic            cpu_acc_type = 1'b0;
  logic [1:0]      cpu_acc_size = '0;
  logic [31:0]     cpu_rdata;
  logic            cpu_wait;
  logic            err_sticky;
  logic            mem_req;
  logic            mem_we;
  logic [MAW-1:0]  mem_addr;
  logic [3:0]      mem_byte_en;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata = '0;
  logic            mem_ack = 1'b0;

  frost32_mem_access_ctrl #(.MEM_ADDR_WIDTH(MAW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_acc_type(cpu_acc_type), .cpu_acc_size(cpu_acc_size),
    .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait), .err_sticky(err_sticky),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          req;
    bit          we;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request; ack_after = number of stall cycles before mem_ack
  // (-1 = never ack). poke keeps cpu_req high while the controller is busy.
  task automatic access(input string tag, input logic typ, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int ack_after, input bit poke,
                        input bit x_req, input bit x_we, input logic [15:0] x_addr,
                        input logic [3:0] x_be, input logic [31:0] x_wdata,
                        input int x_waits, input logic [31:0] x_rdata, input bit x_err);
    exp_t e;
    int waits, cyc;
    bit seen;
    @(negedge clk);
    cpu_req = 1'b1; cpu_acc_type = typ; cpu_acc_size = sz;
    cpu_addr = addr; cpu_wdata = wd; mem_ack = 1'b0;
    e = '{tag, x_req, x_we, x_addr, x_be, x_wdata, x_waits, x_rdata, x_err};
    sb.push_back(e);
    @(negedge clk);
    cpu_req = 1'b0; waits = 0; cyc = 0; seen = 1'b0;
    while (cpu_wait === 1'b1 && waits < 200) begin
      waits++;
      cpu_req = poke;
      if (mem_req === 1'b1) begin
        seen = 1'b1;
        chk({tag, ".we"},    32'(mem_we),      32'(sb[0].we));
        chk({tag, ".addr"},  32'(mem_addr),    32'(sb[0].addr));
        chk({tag, ".be"},    32'(mem_byte_en), 32'(sb[0].be));
        chk({tag, ".wdata"}, mem_wdata,        sb[0].wdata);
        mem_rdata = rd;
        mem_ack   = (cyc == ack_after);
        cyc++;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    cpu_req = 1'b0;
    e = sb.pop_front();
    chk({e.tag, ".waits"},   32'(waits),      32'(e.waits));
    chk({e.tag, ".req"},     32'(seen),       32'(e.req));
    chk({e.tag, ".rdata"},   cpu_rdata,       e.rdata);
    chk({e.tag, ".err"},     32'(err_sticky), 32'(e.err));
    chk({e.tag, ".req_off"}, 32'(mem_req),    32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.rdata", cpu_rdata, 32'd0);
    chk("rst.wait",  32'(cpu_wait), 32'd0);
    chk("rst.err",   32'(err_sticky), 32'd0);
    chk("rst.req",   32'(mem_req), 32'd0);
    chk("rst.we",    32'(mem_we), 32'd0);
    chk("rst.addr",  32'(mem_addr), 32'd0);
    chk("rst.be",    32'(mem_byte_en), 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    //      tag      type       size     addr          wdata         mem_rdata     ack poke  req we addr     be     wdata         waits rdata        err
    access("rd32",   DiatRead,  Dias32,  32'h0000_0010, 32'h0,        32'hDEADBEEF, 0, 0,    1, 0, 16'h4,   4'hF, 32'h0,        1, 32'hDEADBEEF, 0);
    access("wr8",    DiatWrite, Dias8,   32'h0000_0007, 32'h0000_00A5, 32'h0,       0, 0,    1, 1, 16'h1,   4'h8, 32'hA5A5A5A5, 1, 32'hDEADBEEF, 0);
    access("rd16st", DiatRead,  Dias16,  32'h0000_0002, 32'h0,        32'h12345678, 5, 1,    1, 0, 16'h0,   4'hC, 32'h0,        6, 32'h00001234, 0);
    access("rd8hi",  DiatRead,  Dias8,   32'h0000_0103, 32'h0,        32'hAABBCCDD, 0, 0,    1, 0, 16'h40,  4'h8, 32'h0,        1, 32'h000000AA, 0);
    access("wr16",   DiatWrite, Dias16,  32'h0000_0020, 32'hFFFFBEEF, 32'h0,        0, 0,    1, 1, 16'h8,   4'h3, 32'hBEEFBEEF, 1, 32'h000000AA, 0);
    access("wr32mis",DiatWrite, Dias32,  32'h0000_0003, 32'h12345678, 32'h0,       -1, 0,    0, 0, 16'h0,   4'h0, 32'h0,        1, 32'h0,        1);
    access("rd32b",  DiatRead,  Dias32,  32'h0000_0004, 32'h0,        32'h11223344, 0, 0,    1, 0, 16'h1,   4'hF, 32'h0,        1, 32'h11223344, 1);
    access("rd16mis",DiatRead,  Dias16,  32'h0000_0001, 32'h0,        32'h0,       -1, 0,    0, 0, 16'h0,   4'h0, 32'h0,        1, 32'h0,        1);
    access("rd8l1",  DiatRead,  Dias8,   32'h0000_0009, 32'h0,        32'h00007700, 0, 0,    1, 0, 16'h2,   4'h2, 32'h0,        1, 32'h00000077, 1);
    access("rdbad",  DiatRead,  DiasBad, 32'h0000_0000, 32'h0,        32'h0,       -1, 0,    0, 0, 16'h0,   4'h0, 32'h0,        1, 32'h0,        1);
    access("rd32c",  DiatRead,  Dias32,  32'h0000_0020, 32'h0,        32'hFFFFFFFF, 0, 0,    1, 0, 16'h8,   4'hF, 32'h0,        1, 32'hFFFFFFFF, 1);
    access("rdoor",  DiatRead,  Dias8,   32'h0004_0000, 32'h0,        32'h0,       -1, 0,    0, 0, 16'h0,   4'h0, 32'h0,        1, 32'h0,        1);
    access("rd16hi", DiatRead,  Dias16,  32'h0000_001E, 32'h0,        32'h55AA0000, 0, 0,    1, 0, 16'h7,   4'hC, 32'h0,        1, 32'h000055AA, 1);
    access("tmo",    DiatRead,  Dias32,  32'h0000_0008, 32'h0,        32'h0,       -1, 0,    1, 0, 16'h2,   4'hF, 32'h0,      TMO, 32'h0,        1);
    access("wrpost", DiatWrite, Dias32,  32'h0000_000C, 32'hCAFEF00D, 32'h0,        1, 0,    1, 1, 16'h3,   4'hF, 32'hCAFEF00D, 2, 32'h0,        1);

    // Reset in the 2nd wait cycle of a stalled read.
    @(negedge clk);
    cpu_req = 1'b1; cpu_acc_type = DiatRead; cpu_acc_size = Dias32;
    cpu_addr = 32'h0000_0010; cpu_wdata = 32'h0;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rstmid.pre_wait", 32'(cpu_wait), 32'd1);
    chk("rstmid.pre_req",  32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.req",   32'(mem_req), 32'd0);
    chk("rstmid.wait",  32'(cpu_wait), 32'd0);
    chk("rstmid.err",   32'(err_sticky), 32'd0);
    chk("rstmid.rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    access("rd16post", DiatRead, Dias16, 32'h0000_0006, 32'h0,        32'hABCD0000, 0, 0,    1, 0, 16'h1,   4'hC, 32'h0,        1, 32'h0000ABCD, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
